// File: rtl/branch_predictor.sv
// branch_predictor: 2-bit saturating-counter direction predictor with
// B-immediate target generation in IF, training and mispredict redirect in EX,
// and resolved-branch / mispredict statistics counters.
module branch_predictor #(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_instr,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_is_branch,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] br_count,
    output logic [31:0] mp_count
);

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [1:0] CTR_INIT   = 2'b01;

    logic [1:0]        r_table [ENTRIES];
    logic              r_mispredict;
    logic [31:0]       r_redirect_pc;
    logic [31:0]       r_br_count;
    logic [31:0]       r_mp_count;

    logic              w_is_sb;
    logic [IDX_W-1:0]  w_if_idx;
    logic [IDX_W-1:0]  w_ex_idx;
    logic signed [31:0] w_b_imm;
    logic              w_update;
    logic              w_new_mp;
    logic [31:0]       w_redirect_next;
    logic              w_unused_instr;

    // Saturating 2-bit counter step toward the resolved direction.
    function automatic logic [1:0] sat_step(input logic [1:0] c, input logic taken);
        logic [1:0] n;
        n = c;
        if (taken && c != 2'b11) begin
            n = c + 2'd1;
        end else if (!taken && c != 2'b00) begin
            n = c - 2'd1;
        end
        return n;
    endfunction

    // Opcode/index decode and B-type immediate reassembly.
    assign w_is_sb  = (if_instr[6:0] == OPC_BRANCH);
    assign w_if_idx = if_pc[IDX_W+1:2];
    assign w_ex_idx = ex_pc[IDX_W+1:2];
    assign w_b_imm  = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                       if_instr[30:25], if_instr[11:8], 1'b0};

    // Instruction bits that play no part in prediction.
    assign w_unused_instr = &{1'b0, if_instr[24:12]};

    // Prediction reads the table as it stands this cycle, with no bypass of a
    // concurrent EX write, so a same-index update shows up one cycle later.
    assign pred_taken  = if_valid & w_is_sb & r_table[w_if_idx][1];
    assign pred_target = if_pc + w_b_imm;

    // While a redirect is in flight the EX branch is on the wrong path.
    assign w_update        = ex_is_branch & ~r_mispredict;
    assign w_new_mp        = w_update & (ex_taken != ex_pred_taken);
    assign w_redirect_next = ex_taken ? ex_target : (ex_pc + 32'd4);

    // Counter table: reset to weak-not-taken, otherwise train on resolved branches.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_table[i] <= CTR_INIT;
            end
        end else if (w_update) begin
            r_table[w_ex_idx] <= sat_step(r_table[w_ex_idx], ex_taken);
        end
    end

    // One-cycle mispredict pulse with the corrected next PC.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mispredict  <= 1'b0;
            r_redirect_pc <= 32'd0;
        end else begin
            r_mispredict <= w_new_mp;
            if (w_new_mp) begin
                r_redirect_pc <= w_redirect_next;
            end
        end
    end

    // Statistics: every non-suppressed resolved branch, and the mispredicted subset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_br_count <= 32'd0;
            r_mp_count <= 32'd0;
        end else begin
            if (w_update) begin
                r_br_count <= r_br_count + 32'd1;
            end
            if (w_new_mp) begin
                r_mp_count <= r_mp_count + 32'd1;
            end
        end
    end

    assign mispredict  = r_mispredict;
    assign redirect_pc = r_redirect_pc;
    assign br_count    = r_br_count;
    assign mp_count    = r_mp_count;

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the RV32I pipeline, paired with the EX-stage branch comparator. In IF it reads a table of 2-bit saturating counters and predicts direction and target for SB-type instructions. In EX it takes the resolved outcome, trains the table, and raises a one-cycle mispredict/redirect to the PC unit. It also keeps branch and mispredict statistics counters.

## Interface
- ENTRIES, 64, counter-table depth; power of two, 4..1024
- IDX_W, $clog2(ENTRIES), table index width; derived, do not override
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- if_valid  input  1  IF-stage instruction is valid
- if_pc  input  32  IF-stage PC
- if_instr  input  32  IF-stage instruction word
- pred_taken  output  1  predict taken (combinational from table)
- pred_target  output  32  predicted target, if_pc + B-immediate
- ex_is_branch  input  1  EX stage holds a valid SB-type instruction
- ex_pc  input  32  PC of the EX-stage branch
- ex_taken  input  1  resolved direction (Branch from the comparator)
- ex_pred_taken  input  1  prediction made for this branch, piped from IF
- ex_target  input  32  resolved taken target
- mispredict  output  1  registered one-cycle flush/redirect pulse
- redirect_pc  output  32  registered correct next PC, valid while mispredict=1
- br_count  output  32  resolved branches counted
- mp_count  output  32  mispredicts counted

## Operation
- Table: ENTRIES x 2-bit counters. Values are 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Index for both read and write is pc[IDX_W+1:2].
- Predict (combinational):
  - is_sb = (if_instr[6:0] == 7'b1100011).
  - pred_taken = if_valid & is_sb & table[idx(if_pc)][1].
  - pred_target = if_pc + {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0}, with i = if_instr. Addition is 32-bit and wraps modulo 2^32. pred_target is driven whenever is_sb is true, regardless of pred_taken.
- Update is active when ex_is_branch=1 and mispredict=0:
  - ex_taken=1: counter increments, saturating at 11.
  - ex_taken=0: counter decrements, saturating at 00.
  - br_count increments by 1, wrapping at 2^32.
  - If ex_taken != ex_pred_taken: next cycle mispredict=1, mp_count increments, and redirect_pc = ex_taken ? ex_target : ex_pc + 4 (32-bit wrap).
- Wrong-path suppression: in any cycle where mispredict=1, ex_is_branch is ignored. That cycle produces no table write, no count, and no new mispredict.
- Read/write to the same index in one cycle: the prediction returns the old counter value; there is no bypass.
- Aliasing: PCs that differ only outside pc[IDX_W+1:2] share one counter. This is by design.
- Reset (rst_n=0 at a clock edge):
  - All counters become 01.
  - mispredict=0, redirect_pc=0, br_count=0, mp_count=0.
  - Reset takes priority over any simultaneous update.
  - A mispredict computed in the same cycle as reset is discarded.

## Timing
- Prediction: zero latency, combinational from if_pc/if_instr and the current table state.
- Table update: written at the rising edge that ends the EX cycle; visible to predictions in the following cycle.
- mispredict/redirect_pc: registered. Asserted exactly one cycle after the offending EX cycle, for exactly one cycle.
- Two consecutive mispredicting EX cycles: only the first produces a pulse; the second is suppressed as wrong-path. mispredict is never high for two consecutive cycles.
- br_count/mp_count: update one cycle after the EX cycle that causes them.
- Sequential logic is the table, the mispredict/redirect registers and the two counters. Everything else is combinational.

## Test plan
- Reset, then present if_pc=0x100 with if_instr=0x00208463 (beq x1,x2,+8) and if_valid=1. Required: pred_taken=0, pred_target=0x108; br_count=0 and mp_count=0.
- Train: ex_is_branch=1, ex_pc=0x100, ex_taken=1, ex_pred_taken=0, ex_target=0x108. Next cycle: mispredict=1, redirect_pc=0x108, mp_count=1, and IF at 0x100 predicts taken (counter 10). Cycle after: mispredict=0.
- Saturation:
  - Five taken updates at 0x200: counter stays 11, and one not-taken update still predicts taken.
  - Five not-taken updates: counter reaches 00, and one taken update still predicts not-taken.
- Not-taken mispredict: ex_pc=0xFFFFFFFC, ex_taken=0, ex_pred_taken=1. Required: redirect_pc=0x00000000 (wrap), mispredict pulse of 1 cycle.
- Back-to-back: mispredicting EX branches in cycles N and N+1. Required:
  - Exactly one pulse, in cycle N+1.
  - Counter at the second PC unchanged.
  - br_count +1 and mp_count +1.
- Same-index collision and reset priority:
  - Update idx 5 while predicting idx 5 in the same cycle: prediction shows the old value, the new value appears next cycle.
  - Assert rst_n=0 in the same cycle as a mispredicting update: next cycle mispredict=0 and all counters read 01.
